// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and loader ports.
// MEM_ARB_ROUND_ROBIN_EN: a tie goes to the port not served last; otherwise the CPU always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_served,
    output logic o_winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_winner = PORT_CPU;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_served;
        end else if (i_req1) begin
            o_winner = PORT_LOADER;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_served;

    // With no request the result is ignored, so req1 alone decides nothing extra.
    assign o_winner = i_req0 ? PORT_CPU : PORT_LOADER;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single registered-read RAM.
// Define MEM_ARB_ROUND_ROBIN_EN to replace fixed CPU priority with round-robin tie breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_pick;
    logic              w_last_served;
    logic              w_load;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    mem_arb_pick u_pick (
        .i_req0        (req0),
        .i_req1        (req1),
        .i_last_served (w_last_served),
        .o_winner      (w_pick)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer names the port that wins the next tie.
    logic r_rr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= PORT_CPU;
        end else if (r_state == ACK) begin
            r_rr_ptr <= ~r_win;
        end
    end

    assign w_last_served = ~r_rr_ptr;
`else
    assign w_last_served = PORT_LOADER;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req0 || req1) w_next_state = GRANT;
            GRANT:   w_next_state = ACK;
            ACK:     w_next_state = (req0 || req1) ? GRANT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // GRANT is only entered from IDLE or ACK, so this marks a freshly sampled request.
    assign w_load      = (w_next_state == GRANT);
    assign w_sel_we    = (w_pick == PORT_CPU) ? we0    : we1;
    assign w_sel_addr  = (w_pick == PORT_CPU) ? addr0  : addr1;
    assign w_sel_wdata = (w_pick == PORT_CPU) ? wdata0 : wdata1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win       <= PORT_CPU;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_load) begin
            r_win       <= w_pick;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ACK && !r_we) begin
            if (r_win == PORT_CPU) begin
                r_rdata0 <= mem_rdata;
            end else begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    assign gnt0      = (r_state == GRANT) && (r_win == PORT_CPU);
    assign gnt1      = (r_state == GRANT) && (r_win == PORT_LOADER);
    assign ack0      = (r_state == ACK)   && (r_win == PORT_CPU);
    assign ack1      = (r_state == ACK)   && (r_win == PORT_LOADER);
    assign mem_we    = (r_state == GRANT) && r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // The RAM output is itself a register; passing it through during ACK makes read data valid with the ack pulse.
    assign rdata0 = (ack0 && !r_we) ? mem_rdata : r_rdata0;
    assign rdata1 = (ack1 && !r_we) ? mem_rdata : r_rdata1;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: address width of the RAM and of both requester ports.
REQ-002 Parameter DATA_W, default 8: data width of the RAM and of both requester ports.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0/req1  in  1  requester n (0 = CPU, 1 = loader) requests one memory transaction.
REQ-006 we0/we1  in  1  requester n transaction is a write (1) or a read (0).
REQ-007 addr0/addr1  in  ADDR_W  requester n address.
REQ-008 wdata0/wdata1  in  DATA_W  requester n write data.
REQ-009 gnt0/gnt1  out  1  requester n owns the RAM this cycle.
REQ-010 ack0/ack1  out  1  one-cycle pulse marking requester n transaction complete; rdata valid.
REQ-011 rdata0/rdata1  out  DATA_W  read data returned to requester n.
REQ-012 mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_we  out  1  RAM command.
REQ-013 mem_rdata  in  DATA_W  RAM read data, registered: valid one cycle after mem_addr is presented.

Function
REQ-014 FSM states IDLE, GRANT, ACK.
REQ-015 IDLE: if any req is high at the clock edge, select a winner and go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT, one cycle: gnt of the winner = 1; mem_addr/mem_we/mem_wdata driven from the winner's port; then go to ACK.
REQ-017 ACK, one cycle: ack of the winner = 1; rdata of the winner = mem_rdata (captured); mem_we = 0; gnt = 0.
REQ-018 Latency: req sampled at edge N; gnt high during cycle N+1; ack high during cycle N+2.
REQ-019 From ACK: if any req is high at the edge, go directly to GRANT (no idle bubble); otherwise go to IDLE.
REQ-020 Requester holds req/we/addr/wdata stable from req rise until ack; a req still high at the ACK edge is a new transaction.
REQ-021 req dropped during GRANT: the transaction still completes and ack still pulses.
REQ-022 req raised and dropped while the arbiter is busy with the other port is never sampled and gets no ack.
REQ-023 At most one gnt and at most one ack are high in any cycle; mem_we = 1 only in GRANT with a write winner.
REQ-024 rdata of each port holds its last captured value until that port's next ACK; a write transaction leaves rdata unchanged.
REQ-025 Default winner selection (fixed priority): port 0 wins whenever req0 = 1.
REQ-026 All outputs are registered; no combinational path from req to gnt.

Reset
REQ-027 reset low forces IDLE immediately (asynchronous), including mid-transaction.
REQ-028 While reset is low: gnt = 0, ack = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata0 = rdata1 = 0, round-robin pointer = port 0.
REQ-029 A transaction interrupted by reset is abandoned: no ack is issued; the requester must reissue it.
REQ-030 The first req can be sampled at the first rising edge after reset deasserts.

Configuration
REQ-031 With MEM_ARB_ROUND_ROBIN_EN defined, the winner on a tie is the port not served last. The pointer updates on each ACK and starts at port 0 after reset.
REQ-032 With MEM_ARB_ROUND_ROBIN_EN not defined, fixed priority per REQ-025 applies and no pointer register exists.

Structure
REQ-033 Package mem_arb_pkg holds the state encoding (IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2) and the port index constants PORT_CPU = 0 and PORT_LOADER = 1.
REQ-034 Winner selection is a single combinational sub-module, mem_arb_pick (inputs: req0, req1, last-served; output: winner index).

Verification
REQ-035 Single write: req1 = 1, we1 = 1, addr1 = 8'h10, wdata1 = 8'h3C -> gnt1 on cycle N+1 with mem_we = 1 and mem_addr = 8'h10; ack1 on cycle N+2; RAM[8'h10] = 8'h3C.
REQ-036 Read-back: req0 = 1, we0 = 0, addr0 = 8'h10 -> ack0 on cycle N+2 with rdata0 = 8'h3C; rdata1 unchanged.
REQ-037 Tie: req0 = req1 = 1 held for 4 transactions -> fixed priority gives ack0 ×4 with no ack1; with MEM_ARB_ROUND_ROBIN_EN defined, acks alternate 0, 1, 0, 1.
REQ-038 Back-to-back: req0 held for 3 reads of addresses 8'h00, 8'h01, 8'h02 -> acks on cycles N+2, N+4, N+6; no IDLE cycle between them.
REQ-039 Reset mid-transaction: reset low during GRANT of a write to 8'h20 -> gnt = 0 and mem_we = 0 immediately; no ack issued; FSM in IDLE.
REQ-040 Every cycle (assertion): gnt0 & gnt1 = 0 and ack0 & ack1 = 0; mem_we = 1 only when a gnt is high.
